// File: rtl/ias_control_sequencer.sv
// Two-instructions-per-word control sequencer: FETCH, then DECODE/EXECUTE for the left half, then the right half.
// Optional memory-ack watchdog enabled by defining IAS_CU_WAIT_TIMEOUT_EN.
module ias_control_sequencer #(
    parameter int EXEC_W         = 4,
    parameter int RET_W          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mem_ack,
    input  logic [EXEC_W-1:0] exec_cycles,
    input  logic              halt_op,
    input  logic              jump_taken,
    output logic [2:0]        state,
    output logic              mem_req,
    output logic              fetch_en,
    output logic              decode_en,
    output logic              exec_en,
    output logic              sel_right,
    output logic              last_exec,
    output logic              halted,
    output logic [RET_W-1:0]  retire_count,
    output logic              wait_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [EXEC_W-1:0] cnt_q, cnt_d;
    logic              sel_right_q, sel_right_d;
    logic [RET_W-1:0]  retire_q, retire_d;
    logic              wait_err_q, wait_err_d;
    logic              wd_expired;

`ifdef IAS_CU_WAIT_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;

    // Counter is zero whenever we are outside FETCH, so entry always starts from zero.
    always_comb begin
        wd_d = '0;
        if (state_q == S_FETCH && !mem_ack)
            wd_d = wd_q + WD_W'(1);
    end

    assign wd_expired = (state_q == S_FETCH) && !mem_ack && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wd_q <= '0;
        else       wd_q <= wd_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign wd_expired     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_right_d = sel_right_q;
        retire_d    = retire_q;
        wait_err_d  = wait_err_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ack) begin
                    sel_right_d = 1'b0;
                    state_d     = S_DECODE;
                end else if (wd_expired) begin
                    wait_err_d = 1'b1;
                    state_d    = S_HALT;
                end
            end
            S_DECODE: begin
                if (halt_op) begin
                    state_d = S_HALT;
                end else begin
                    cnt_d   = (exec_cycles == '0) ? EXEC_W'(1) : exec_cycles;
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                cnt_d = cnt_q - EXEC_W'(1);
                if (cnt_q == EXEC_W'(1)) begin
                    retire_d = retire_q + RET_W'(1);
                    // A redirect discards the right half of the current word.
                    if (jump_taken) begin
                        sel_right_d = 1'b0;
                        state_d     = S_FETCH;
                    end else if (!sel_right_q) begin
                        sel_right_d = 1'b1;
                        state_d     = S_DECODE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sel_right_q <= 1'b0;
            retire_q    <= '0;
            wait_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_right_q <= sel_right_d;
            retire_q    <= retire_d;
            wait_err_q  <= wait_err_d;
        end
    end

    assign state        = state_q;
    assign mem_req      = (state_q == S_FETCH);
    assign fetch_en     = (state_q == S_FETCH) && mem_ack;
    assign decode_en    = (state_q == S_DECODE);
    assign exec_en      = (state_q == S_EXECUTE);
    assign last_exec    = (state_q == S_EXECUTE) && (cnt_q == EXEC_W'(1));
    assign halted       = (state_q == S_HALT);
    assign sel_right    = sel_right_q;
    assign retire_count = retire_q;
    assign wait_err     = wait_err_q;

endmodule

// File: tb/tb_ias_control_sequencer.sv
// Directed vector bench for ias_control_sequencer; exercises the watchdog when IAS_CU_WAIT_TIMEOUT_EN is defined.
module tb_ias_control_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mem_ack = 1'b0;
    logic [3:0]  exec_cycles = '0;
    logic        halt_op = 1'b0;
    logic        jump_taken = 1'b0;
    logic [2:0]  state;
    logic        mem_req, fetch_en, decode_en, exec_en, sel_right, last_exec, halted, wait_err;
    logic [15:0] retire_count;

    int total = 0;
    int bad = 0;

    ias_control_sequencer #(.EXEC_W(4), .RET_W(16), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_ack(mem_ack),
        .exec_cycles(exec_cycles), .halt_op(halt_op), .jump_taken(jump_taken),
        .state(state), .mem_req(mem_req), .fetch_en(fetch_en), .decode_en(decode_en),
        .exec_en(exec_en), .sel_right(sel_right), .last_exec(last_exec), .halted(halted),
        .retire_count(retire_count), .wait_err(wait_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start, ack;
        logic [3:0] exec;
        logic       halt, jump;
        logic [2:0] st;
        logic       mreq, fen, den, een, sel, last, hlt;
        logic [15:0] ret;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic s, logic a, logic [3:0] e, logic h, logic j,
                                logic [2:0] st, logic mr, logic fe, logic de, logic ee,
                                logic sl, logic la, logic hl, logic [15:0] r);
        vec_t v;
        v.start = s; v.ack = a; v.exec = e; v.halt = h; v.jump = j;
        v.st = st; v.mreq = mr; v.fen = fe; v.den = de; v.een = ee;
        v.sel = sl; v.last = la; v.hlt = hl; v.ret = r;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (vec %0d): got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            start = tbl[i].start; mem_ack = tbl[i].ack; exec_cycles = tbl[i].exec;
            halt_op = tbl[i].halt; jump_taken = tbl[i].jump;
            #1;
            chk("state", i, 16'(state), 16'(tbl[i].st));
            chk("mem_req", i, 16'(mem_req), 16'(tbl[i].mreq));
            chk("fetch_en", i, 16'(fetch_en), 16'(tbl[i].fen));
            chk("decode_en", i, 16'(decode_en), 16'(tbl[i].den));
            chk("exec_en", i, 16'(exec_en), 16'(tbl[i].een));
            chk("sel_right", i, 16'(sel_right), 16'(tbl[i].sel));
            chk("last_exec", i, 16'(last_exec), 16'(tbl[i].last));
            chk("halted", i, 16'(halted), 16'(tbl[i].hlt));
            chk("retire_count", i, retire_count, tbl[i].ret);
            chk("wait_err", i, 16'(wait_err), 16'd0);
        end
    endtask

    task automatic clear_inputs();
        start = 0; mem_ack = 0; exec_cycles = '0; halt_op = 0; jump_taken = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        //                 start ack exec halt jump | st mreq fen den een sel last hlt ret
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 2, 0, 0, 1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0, 2));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 2));
        tbl.push_back(mk(0, 0, 3, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1, 0, 3, 0, 0, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0, 0, 1, 0, 1, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 1, 1, 0, 3));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 4));
        tbl.push_back(mk(0, 0, 2, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 0, 0, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 0, 1, 0, 4));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 5));
        tbl.push_back(mk(0, 0, 2, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 5));
        // index 22: halt sequence after reset
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 7, 1, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 4, 0, 0, 0, 0, 0, 0, 1, 0));

        #1;
        chk("reset_state", -1, 16'(state), 16'd0);
        chk("reset_retire", -1, retire_count, 16'd0);
        do_reset();
        run_vecs(0, 21);

        // asynchronous reset in the middle of EXECUTE, between clock edges
        reset = 1'b1;
        #1;
        chk("async_rst_state", -1, 16'(state), 16'd0);
        chk("async_rst_retire", -1, retire_count, 16'd0);
        chk("async_rst_exec_en", -1, 16'(exec_en), 16'd0);
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;

        run_vecs(22, 28);
        reset = 1'b1;
        #1;
        chk("halt_reset_state", -1, 16'(state), 16'd0);
        chk("halt_reset_halted", -1, 16'(halted), 16'd0);

        // maximum execute length
        do_reset();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0; mem_ack = 1;
        @(negedge clk); mem_ack = 0; exec_cycles = 4'd15;
        #1;
        chk("max_decode_state", -1, 16'(state), 16'd2);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (exec_en) n++;
            else break;
        end
        chk("max_exec_len", -1, 16'(n), 16'd15);
        chk("max_exec_next", -1, 16'(state), 16'd2);
        chk("max_exec_sel", -1, 16'(sel_right), 16'd1);
        chk("max_exec_retire", -1, retire_count, 16'd1);

        // memory wait without ack
        do_reset();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
`ifdef IAS_CU_WAIT_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("wd_fetch_state", k, 16'(state), 16'd1);
            chk("wd_fetch_err", k, 16'(wait_err), 16'd0);
            @(negedge clk);
        end
        #1;
        chk("wd_timeout_state", -1, 16'(state), 16'd4);
        chk("wd_timeout_err", -1, 16'(wait_err), 16'd1);
        chk("wd_timeout_halted", -1, 16'(halted), 16'd1);

        do_reset();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("wd_ack_fetch_state", k, 16'(state), 16'd1);
            @(negedge clk);
        end
        mem_ack = 1;
        #1;
        chk("wd_ack_fetch_en", -1, 16'(fetch_en), 16'd1);
        @(negedge clk); mem_ack = 0;
        #1;
        chk("wd_ack_state", -1, 16'(state), 16'd2);
        chk("wd_ack_err", -1, 16'(wait_err), 16'd0);
`else
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("nowd_fetch_state", k, 16'(state), 16'd1);
            chk("nowd_err", k, 16'(wait_err), 16'd0);
            @(negedge clk);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
